// File: rtl/counter_pkg.sv
// Shared types and constants for the BCD counter library.
package counter_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RUN     = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  // Saturate a nibble to the largest legal BCD digit.
  function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One BCD digit of a decrementer chain: subtracts the borrow-in and
// produces a borrow-out when the digit wraps from 0 to 9.
module bcd_digit_dec
  import counter_pkg::*;
(
  input  logic [BCD_W-1:0] d,
  input  logic             bin,
  output logic [BCD_W-1:0] q,
  output logic             bout
);

  // A zero digit wraps to 9 and passes the borrow on; anything else absorbs it.
  always_comb begin
    q    = d;
    bout = 1'b0;
    if (bin) begin
      if (d == '0) begin
        q    = BCD_MAX;
        bout = 1'b1;
      end else begin
        q = d - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with prescaler, pause, load clamp and
// a one-cycle done pulse when the count reaches zero by decrementing.
module bcd_countdown_timer
  import counter_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   cnt,
  output logic                  zero,
  output logic                  done,
  output logic                  busy
);

  localparam int CW = BCD_W * DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   pre_q, pre_d;
  logic            done_q, done_d;

  logic [CW-1:0]   dec_val;
  logic [CW-1:0]   clamp_val;
  logic [DIGITS:0] borrow;

  // The ripple borrow reaching past the top digit means the count is zero,
  // which doubles as the guard against underflow.
  assign borrow[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit_dec u_dec (
      .d    (cnt_q[i*BCD_W +: BCD_W]),
      .bin  (borrow[i]),
      .q    (dec_val[i*BCD_W +: BCD_W]),
      .bout (borrow[i+1])
    );
  end

  // Saturate every incoming digit so the count is always valid BCD.
  always_comb begin
    clamp_val = '0;
    for (int i = 0; i < DIGITS; i++) begin
      clamp_val[i*BCD_W +: BCD_W] = bcd_clamp(load_val[i*BCD_W +: BCD_W]);
    end
  end

  // Next-state logic: load overrides everything, otherwise only ARMED/RUN
  // react to en, ticking the prescaler and decrementing on its wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
    if (load) begin
      cnt_d   = clamp_val;
      pre_d   = '0;
      state_d = (clamp_val != '0) ? ARMED : IDLE;
    end else begin
      case (state_q)
        ARMED, RUN: begin
          if (en) begin
            state_d = RUN;
            if (pre_q != PRE_LAST) begin
              pre_d = pre_q + PW'(1);
            end else begin
              pre_d = '0;
              if (!borrow[DIGITS]) begin
                cnt_d = dec_val;
                if (dec_val == '0) begin
                  done_d  = 1'b1;
                  state_d = EXPIRED;
                end
              end
            end
          end else begin
            state_d = ARMED;
          end
        end
        default: ;
      endcase
    end
  end

  // All state, count, prescaler and the done pulse live in one register bank.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
    end
  end

  assign cnt  = cnt_q;
  assign done = done_q;
  assign zero = (cnt_q == '0);
  assign busy = (state_q == ARMED) || (state_q == RUN);

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: two instances (default 2-digit/div-10 and
// 3-digit/div-1) compared each cycle against an integer reference model.
module tb_bcd_countdown_timer;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_a = 1'b0, en_a = 1'b0;
  logic [7:0]  lv_a = '0;
  logic [7:0]  cnt_a;
  logic        zero_a, done_a, busy_a;
  logic        load_b = 1'b0, en_b = 1'b0;
  logic [11:0] lv_b = '0;
  logic [11:0] cnt_b;
  logic        zero_b, done_b, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain decimal value, prescaler count and an active flag.
  int m_val[2];
  int m_pre[2];
  bit m_active[2];
  bit m_done[2];
  int td[2] = '{10, 1};
  int nd[2] = '{2, 3};

  always #5 clk = ~clk;

  bcd_countdown_timer #(.DIGITS(2), .TICK_DIV(10)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .load(load_a), .load_val(lv_a),
    .cnt(cnt_a), .zero(zero_a), .done(done_a), .busy(busy_a)
  );

  bcd_countdown_timer #(.DIGITS(3), .TICK_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .load(load_b), .load_val(lv_b),
    .cnt(cnt_b), .zero(zero_b), .done(done_b), .busy(busy_b)
  );

  function automatic int clampedValue(input logic [11:0] lv, input int k);
    int v = 0;
    int mult = 1;
    int d;
    for (int i = 0; i < nd[k]; i++) begin
      d = int'(lv[i*4 +: 4]);
      if (d > 9) d = 9;
      v += d * mult;
      mult *= 10;
    end
    return v;
  endfunction

  function automatic logic [11:0] toBcd(input int v);
    logic [11:0] r = '0;
    int t = v;
    for (int i = 0; i < 3; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 0; m_pre[k] = 0; m_active[k] = 1'b0; m_done[k] = 1'b0;
    end
  endtask

  task automatic modelStep(input int k, input bit ld, input logic [11:0] lv, input bit e);
    m_done[k] = 1'b0;
    if (ld) begin
      m_val[k]    = clampedValue(lv, k);
      m_pre[k]    = 0;
      m_active[k] = (m_val[k] != 0);
    end else if (m_active[k] && e) begin
      if (m_pre[k] < td[k] - 1) begin
        m_pre[k]++;
      end else begin
        m_pre[k] = 0;
        m_val[k]--;
        if (m_val[k] == 0) begin
          m_done[k]   = 1'b1;
          m_active[k] = 1'b0;
        end
      end
    end
  endtask

  // Drive one DUT for one clock edge (the other sits idle) and step both models.
  task automatic applyStimulus(input int k, input bit ld, input logic [11:0] lv, input bit e);
    if (k == 0) begin
      load_a = ld; lv_a = lv[7:0]; en_a = e; load_b = 1'b0; en_b = 1'b0;
    end else begin
      load_b = ld; lv_b = lv; en_b = e; load_a = 1'b0; en_a = 1'b0;
    end
    @(posedge clk);
    modelStep(0, load_a, {4'h0, lv_a}, en_a);
    modelStep(1, load_b, lv_b, en_b);
    #1;
  endtask

  task automatic checkValue(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input int k, input string tag);
    logic [11:0] c;
    logic z, d, b;
    if (k == 0) begin
      c = {4'h0, cnt_a}; z = zero_a; d = done_a; b = busy_a;
    end else begin
      c = cnt_b; z = zero_b; d = done_b; b = busy_b;
    end
    checkValue({tag, ".cnt"},  c, toBcd(m_val[k]));
    checkValue({tag, ".zero"}, {11'b0, z}, {11'b0, (m_val[k] == 0)});
    checkValue({tag, ".done"}, {11'b0, d}, {11'b0, m_done[k]});
    checkValue({tag, ".busy"}, {11'b0, b}, {11'b0, m_active[k]});
  endtask

  // Directed test-plan steps followed by randomized traffic on both instances.
  initial begin
    int done_cnt;
    bit rl, re;
    logic [11:0] rv;

    modelReset();
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    checkOutput(0, "rst_init_a");
    checkOutput(1, "rst_init_b");
    @(negedge clk);
    rst = 1'b0;

    // Load 25 and run it all the way down.
    applyStimulus(0, 1'b1, 12'h025, 1'b0);
    checkOutput(0, "load25");
    done_cnt = 0;
    for (int i = 1; i <= 250; i++) begin
      applyStimulus(0, 1'b0, 12'h000, 1'b1);
      checkOutput(0, "run25");
      if (done_a) done_cnt++;
      if (i == 10)  checkValue("after10",  {4'h0, cnt_a}, 12'h024);
      if (i == 50)  checkValue("at20",     {4'h0, cnt_a}, 12'h020);
      if (i == 60)  checkValue("borrow19", {4'h0, cnt_a}, 12'h019);
      if (i == 250) checkValue("expired",  {4'h0, cnt_a, 1'b0, 1'b0, done_a, busy_a} >> 2, {4'h0, 8'h00} | 12'h000);
    end
    checkValue("done_pulses_a", 12'(done_cnt), 12'd1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1'b0, 12'h000, 1'b1);
      checkOutput(0, "hold0");
    end

    // Pause mid-count and resume.
    applyStimulus(0, 1'b1, 12'h012, 1'b0);
    for (int i = 0; i < 15; i++) begin
      applyStimulus(0, 1'b0, 12'h000, 1'b1);
      checkOutput(0, "pause_run");
    end
    checkValue("pause_11", {4'h0, cnt_a}, 12'h011);
    for (int i = 0; i < 30; i++) begin
      applyStimulus(0, 1'b0, 12'h000, 1'b0);
      checkOutput(0, "paused");
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1'b0, 12'h000, 1'b1);
      checkOutput(0, "resume");
    end
    checkValue("resume_10", {4'h0, cnt_a}, 12'h010);

    // Clamp of illegal digits, then a zero load.
    applyStimulus(0, 1'b1, 12'h0AF, 1'b0);
    checkOutput(0, "clamp");
    checkValue("clamp_99", {4'h0, cnt_a}, 12'h099);
    checkValue("clamp_busy", {11'b0, busy_a}, 12'd1);
    applyStimulus(0, 1'b1, 12'h000, 1'b0);
    checkOutput(0, "load0");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 1'b0, 12'h000, 1'b1);
      checkOutput(0, "idle_en");
    end

    // Load colliding with the terminal decrement.
    applyStimulus(0, 1'b1, 12'h001, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(0, 1'b0, 12'h000, 1'b1);
    applyStimulus(0, 1'b1, 12'h007, 1'b1);
    checkOutput(0, "collide");
    checkValue("collide_cnt",  {4'h0, cnt_a}, 12'h007);
    checkValue("collide_done", {11'b0, done_a}, 12'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1'b0, 12'h000, 1'b1);
      checkOutput(0, "collide_run");
    end

    // en dropping on the terminal cycle defers the decrement.
    applyStimulus(0, 1'b1, 12'h001, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(0, 1'b0, 12'h000, 1'b1);
    applyStimulus(0, 1'b0, 12'h000, 1'b0);
    checkOutput(0, "term_pause");
    applyStimulus(0, 1'b0, 12'h000, 1'b1);
    checkOutput(0, "term_resume");
    checkValue("term_done", {11'b0, done_a}, 12'd1);

    // Asynchronous reset mid-count, then en alone must not restart.
    applyStimulus(0, 1'b1, 12'h030, 1'b0);
    for (int i = 0; i < 23; i++) applyStimulus(0, 1'b0, 12'h000, 1'b1);
    #3 rst = 1'b1;
    #1;
    modelReset();
    checkOutput(0, "async_rst");
    checkValue("async_rst_cnt", {4'h0, cnt_a}, 12'h000);
    #2 rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(0, 1'b0, 12'h000, 1'b1);
      checkOutput(0, "post_rst");
    end

    // Random traffic on the 2-digit instance.
    for (int i = 0; i < 1500; i++) begin
      rl = ($urandom_range(0, 119) == 0);
      rv = 12'($urandom_range(0, 255));
      re = ($urandom_range(0, 9) < 8);
      applyStimulus(0, rl, rv, re);
      checkOutput(0, "rand_a");
    end

    // 3-digit, TICK_DIV=1 instance: 100 counts down in 100 edges.
    applyStimulus(1, 1'b1, 12'h100, 1'b0);
    checkOutput(1, "load100");
    done_cnt = 0;
    for (int i = 1; i <= 100; i++) begin
      applyStimulus(1, 1'b0, 12'h000, 1'b1);
      checkOutput(1, "run100");
      if (done_b) done_cnt++;
      if (i == 1)   checkValue("first_099", cnt_b, 12'h099);
      if (i == 100) checkValue("end_000",   cnt_b, 12'h000);
    end
    checkValue("done_pulses_b", 12'(done_cnt), 12'd1);

    // Random traffic on the 3-digit instance.
    for (int i = 0; i < 800; i++) begin
      rl = ($urandom_range(0, 39) == 0);
      rv = 12'($urandom());
      re = ($urandom_range(0, 9) < 7);
      applyStimulus(1, rl, rv, re);
      checkOutput(1, "rand_b");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Cascadable BCD down-counter with load, pause and terminal-count detection: the countdown counterpart of `counter_0to9`. It counts a loaded multi-digit decimal value down to zero at a prescaled rate while `en` is high. It pulses `done` on reaching zero and then holds until reloaded. It sits beside `counter_0to9` in the counter library and drives display and timeout logic.

## Interface
- `DIGITS`, 2: number of BCD digits; must be ≥ 1.
- `TICK_DIV`, 10: enabled clock cycles per decrement; must be ≥ 1.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  count enable; low pauses the count and the prescaler.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  4*DIGITS  BCD value to load; digit 0 is in bits [3:0].
- `cnt`  out  4*DIGITS  current BCD count.
- `zero`  out  1  high when `cnt` == 0.
- `done`  out  1  one-cycle pulse on the edge where `cnt` becomes 0 by decrement.
- `busy`  out  1  high in ARMED or RUN.

## Operation
- States:
  - IDLE: zero count, never started.
  - ARMED: loaded and paused.
  - RUN: counting.
  - EXPIRED: reached zero by counting.
- Reset values: state IDLE, `cnt`=0, prescaler=0, `zero`=1, `done`=0, `busy`=0.
- `load`=1 is accepted in any state and has highest priority:
  - Each load digit > 9 is clamped to 9.
  - `cnt` takes the clamped value and the prescaler clears.
  - Next state is ARMED if the clamped value ≠ 0, otherwise IDLE.
  - `done` stays 0 on a load cycle.
- ARMED, `en`=1 → RUN. RUN, `en`=0 → ARMED. The prescaler and `cnt` hold while paused.
- In ARMED or RUN with `en`=1:
  - If prescaler < TICK_DIV-1, the prescaler increments.
  - Otherwise the prescaler returns to 0 and `cnt` decrements by one in BCD.
- BCD decrement:
  - Digit 0 always receives a borrow-in.
  - A digit at 0 with borrow-in becomes 9 and borrows from the next digit.
  - Any other digit with borrow-in decrements and stops the borrow.
  - The value never underflows, because decrement only occurs when `cnt` ≠ 0.
- When a decrement yields 0: `done`=1 for that one cycle and state → EXPIRED.
- IDLE and EXPIRED ignore `en`. `cnt` holds 0 until `load`.
- `zero` and `busy` are decoded from the registered `cnt` and state, with no extra latency.

## Timing
- All outputs are registered or decoded from registers. There is no combinational input-to-output path.
- With `en` held high from the cycle after `load`:
  - The first decrement is visible TICK_DIV edges after the first `en` edge.
  - A loaded value N reaches 0 after N·TICK_DIV enabled edges.
- TICK_DIV=1: one decrement per enabled edge; the prescaler is a constant 0.
- Prescaler width is max(1, clog2(TICK_DIV)).
- `done` rises on the same edge where `cnt` becomes 0 and `zero` rises. It falls on the next edge.
- `load` coincident with a terminal decrement: the load wins, with no `done` and no transition to EXPIRED.
- `en` dropping on a terminal cycle: no decrement; the count resumes from the held prescaler value.
- `rst` mid-count: all outputs go to their reset values immediately, without waiting for `clk`. The first count after release needs a fresh `load`.

## Structure
- Package `counter_pkg` holds:
  - the state typedef (IDLE/ARMED/RUN/EXPIRED, 2-bit);
  - `BCD_MAX` = 4'd9;
  - the BCD digit width constant (4).
- Sub-module `bcd_digit_dec`: one BCD digit with borrow.
  - Inputs: `d`[3:0], `bin`. Outputs: `q`[3:0], `bout`.
  - Purely combinational; instantiated DIGITS times in a generate chain.
- The top level owns the FSM, prescaler, clamp logic and output registers.

## Test plan
- Reset check: assert `rst` asynchronously between clock edges → `cnt`=00, `zero`=1, `done`=0, `busy`=0 before the next edge.
- Defaults, `load_val`=0x25 then `en`=1 held:
  - After 10 enabled edges `cnt`=0x24.
  - Crossing 0x20→0x19 borrows correctly.
  - After 250 enabled edges `cnt`=0x00 with `done` high exactly one cycle; `busy`=0 and `cnt` stays 0 with `en` still high.
- Pause: load 0x12, run 15 enabled edges (`cnt`=0x11, prescaler=5), drop `en` for 30 cycles → `cnt` and prescaler frozen. Re-assert `en` → 0x10 after 5 more edges.
- Clamp and zero load:
  - `load_val`=0xAF → `cnt`=0x99, state ARMED.
  - `load_val`=0x00 → IDLE, `zero`=1, `done` never asserts.
- Collision: `cnt`=0x01 with prescaler=9, apply `load`=1 with 0x07 and `en`=1 on the same edge → `cnt`=0x07, `done`=0, state ARMED or RUN (RUN if `en` stays high).
- TICK_DIV=1, DIGITS=3: load 0x100, `en`=1 → next edge 0x099. After 100 edges 0x000 with a single `done` pulse.
